// File: rtl/uart_fifo_periph.sv
// uart_fifo_periph: memory-mapped full-duplex UART for the 6502 system bus.
// It has a TX FIFO feeding a serial shifter, and a receiver with mid-bit
// sampling that feeds an RX FIFO. It also has status, control and count
// registers and a registered level interrupt.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   addr      register select (0 DATA, 1 STATUS, 2 CTRL, 3 RXCOUNT)
//   data_in   write data
//   data_out  read data, combinational from addr
//   cs        chip select
//   we        write strobe (acts when cs & we)
//   re        read strobe (acts when cs & re; pops RX FIFO on addr 0)
//   tx        serial out, idles high
//   rx        serial in, asynchronous
//   irq       active-high level interrupt

// Byte FIFO.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
// A pop from an empty FIFO is ignored.
// Ports: i_push/i_pop strobes, i_data write byte, o_head oldest byte,
// o_count occupancy, o_full/o_empty flags.
module uart_fifo_periph_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [7:0]             i_data,
    output logic [7:0]             o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = r_mem[r_rp];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + AW'(1);
            if (w_pop_ok)  r_rp <= r_rp + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module uart_fifo_periph #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       cs,
    input  logic       we,
    input  logic       re,
    output logic       tx,
    input  logic       rx,
    output logic       irq
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] C_BIT_END  = BW'(DIV - 1);
    localparam logic [BW-1:0] C_HALF_END = BW'(DIV / 2 - 1);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    // Bus decode
    logic w_tx_push, w_rx_pop, w_w1c, w_ctrl_wr;
    assign w_tx_push = cs & we & (addr == 2'd0);
    assign w_rx_pop  = cs & re & (addr == 2'd0);
    assign w_w1c     = cs & we & (addr == 2'd1);
    assign w_ctrl_wr = cs & we & (addr == 2'd2);

    // TX FIFO
    logic [7:0]    w_tx_head;
    logic [CW-1:0] w_tx_count;
    logic          w_tx_full, w_tx_empty, w_tx_pop;

    uart_fifo_periph_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_data  (data_in),
        .o_head  (w_tx_head),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    // TX shifter
    logic [1:0]    r_tx_state;
    logic [BW-1:0] r_tx_baud;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx_line;
    logic          r_tx_busy;
    logic          w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_baud == C_BIT_END);
    // The FIFO is drained from IDLE, and also on the last STOP cycle so that
    // queued frames go out back-to-back.
    assign w_tx_pop = ~w_tx_empty &
                      ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_bit_end));

    always_ff @(posedge clk) begin
        if (w_tx_pop)
            r_tx_shift <= w_tx_head;
        else if (w_tx_bit_end && (r_tx_state == TX_START || r_tx_state == TX_DATA))
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_line  <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_state <= TX_START;
                        r_tx_baud  <= '0;
                        r_tx_line  <= 1'b0;
                        r_tx_busy  <= 1'b1;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_state <= TX_DATA;
                        r_tx_baud  <= '0;
                        r_tx_bit   <= '0;
                        r_tx_line  <= r_tx_shift[0];
                    end else begin
                        r_tx_baud <= r_tx_baud + BW'(1);
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_baud <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_tx_line  <= 1'b1;
                        end else begin
                            r_tx_bit  <= r_tx_bit + 3'd1;
                            r_tx_line <= r_tx_shift[0];
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + BW'(1);
                    end
                end
                default: begin // TX_STOP
                    if (w_tx_bit_end) begin
                        r_tx_baud <= '0;
                        if (w_tx_pop) begin
                            r_tx_state <= TX_START;
                            r_tx_line  <= 1'b0;
                        end else begin
                            r_tx_state <= TX_IDLE;
                            r_tx_busy  <= 1'b0;
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + BW'(1);
                    end
                end
            endcase
        end
    end

    // RX synchroniser; it resets to the idle line level so no false start
    // edge is seen after reset.
    logic r_rx_s1, r_rx_s2, r_rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX deserialiser
    logic [2:0]    r_rx_state;
    logic [BW-1:0] r_rx_baud;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          w_rx_fall, w_rx_bit_end, w_rx_stop_smp;
    logic          w_rx_push, w_frame_err, w_overrun;
    logic [7:0]    w_rx_head;
    logic [CW-1:0] w_rx_count;
    logic          w_rx_full, w_rx_empty;

    assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
    assign w_rx_bit_end  = (r_rx_baud == C_BIT_END);
    assign w_rx_stop_smp = (r_rx_state == RX_STOP) & w_rx_bit_end;
    assign w_rx_push     = w_rx_stop_smp & r_rx_s2;
    assign w_frame_err   = w_rx_stop_smp & ~r_rx_s2;
    // A full FIFO still accepts the byte if the CPU pops in the same cycle.
    assign w_overrun     = w_rx_push & w_rx_full & ~w_rx_pop;

    uart_fifo_periph_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_data  (r_rx_shift),
        .o_head  (w_rx_head),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_ff @(posedge clk) begin
        if (r_rx_state == RX_DATA && w_rx_bit_end)
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_START;
                        r_rx_baud  <= '0;
                    end
                end
                RX_START: begin
                    // Re-check at mid start bit; a high line means a glitch.
                    if (r_rx_baud == C_HALF_END) begin
                        r_rx_baud  <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_baud <= r_rx_baud + BW'(1);
                    end
                end
                RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_baud <= '0;
                        r_rx_bit  <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_baud <= r_rx_baud + BW'(1);
                    end
                end
                RX_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_baud  <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT;
                    end else begin
                        r_rx_baud <= r_rx_baud + BW'(1);
                    end
                end
                RX_WAIT: begin
                    if (r_rx_s2) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Registers and interrupt
    logic [1:0] r_ctrl;
    logic       r_ovr, r_fe, r_irq;
    logic [7:0] w_status;
    logic [7:0] w_rx_count8;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= '0;
            r_ovr  <= 1'b0;
            r_fe   <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ctrl <= data_in[1:0];
            // A new event in the same cycle as the clear wins.
            r_ovr <= (r_ovr & ~(w_w1c & data_in[5])) | w_overrun;
            r_fe  <= (r_fe  & ~(w_w1c & data_in[6])) | w_frame_err;
            r_irq <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_empty & ~r_tx_busy);
        end
    end

    assign w_status    = {1'b0, r_fe, r_ovr, r_tx_busy, w_rx_full, ~w_rx_empty,
                          w_tx_full, w_tx_empty};
    assign w_rx_count8 = 8'(w_rx_count);

    always_comb begin
        data_out = 8'h00;
        case (addr)
            2'd0:    data_out = w_rx_empty ? 8'h00 : w_rx_head;
            2'd1:    data_out = w_status;
            2'd2:    data_out = {6'b0, r_ctrl};
            default: data_out = w_rx_count8;
        endcase
    end

    assign tx  = r_tx_line;
    assign irq = r_irq;
endmodule

// File: tb/tb_uart_fifo_periph.sv
// tb_uart_fifo_periph: self-checking bench for uart_fifo_periph with DIV=10
// and 16-entry FIFOs. A register vector table covers the reset state and the
// CTRL/STATUS access rules. Hand-written sequences cover TX framing and
// back-to-back frames, TX FIFO overflow, RX receive/pop/irq, glitch and
// framing rejection, RX overrun, and reset in the middle of a frame.
module tb_uart_fifo_periph;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       tx;
    logic       rx = 1'b1;
    logic       irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_fifo_periph #(
        .CLK_FREQ   (1000000),
        .BAUD_RATE  (100000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .cs       (cs),
        .we       (we),
        .re       (re),
        .tx       (tx),
        .rx       (rx),
        .irq      (irq)
    );

    typedef struct {
        logic       wr;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); cs = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk); cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); cs = 1'b1; re = 1'b1; addr = a;
        #1 d = data_out;
        @(negedge clk); cs = 1'b0; re = 1'b0;
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        #1 d = data_out;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rx = f[i];
            repeat (9) @(negedge clk);
        end
        @(negedge clk); rx = 1'b1;
    endtask

    // Decode one frame from tx: find the start bit, then sample mid-bit.
    task automatic grab_tx(output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b0;
        b  = 8'h00;
        n  = 0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        repeat (5) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = tx;
        end
        repeat (10) @(negedge clk);
        ok = (tx === 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [19:0] line;
        int          errs;

        vecs[0] = '{1'b0, 2'd1, 8'h00, 8'h01};
        vecs[1] = '{1'b0, 2'd2, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 2'd3, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 2'd0, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 2'd2, 8'hFF, 8'h00};
        vecs[5] = '{1'b0, 2'd2, 8'h00, 8'h03};
        vecs[6] = '{1'b1, 2'd1, 8'hFF, 8'h00};
        vecs[7] = '{1'b0, 2'd1, 8'h00, 8'h01};
        vecs[8] = '{1'b1, 2'd2, 8'h00, 8'h00};
        vecs[9] = '{1'b0, 2'd2, 8'h00, 8'h00};

        // 1. Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("reset tx", tx, 1);
        check("reset irq", irq, 0);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].a, vecs[i].d);
            end else begin
                bus_read(vecs[i].a, d);
                check($sformatf("vec%0d addr%0d", i, vecs[i].a), d, vecs[i].exp);
            end
        end

        // 2. Two back-to-back frames, TX-idle interrupt
        bus_write(2'd2, 8'h02);
        line = {1'b1, 8'h41, 1'b0, 1'b1, 8'h58, 1'b0};
        @(negedge clk); cs = 1'b1; we = 1'b1; addr = 2'd0; data_in = 8'h58;
        @(negedge clk); data_in = 8'h41;
        check("tx high at N+1", tx, 1);
        @(negedge clk); cs = 1'b0; we = 1'b0;
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (tx !== line[k/10]) errs++;
            if (k % 10 == 9) begin
                check($sformatf("line bit %0d wrong samples", k/10), errs, 0);
                errs = 0;
            end
        end
        @(negedge clk);
        peek(2'd1, d);
        check("busy cleared after stop", d[4], 0);
        check("irq not yet up", irq, 0);
        @(negedge clk);
        check("irq one cycle after idle", irq, 1);

        // 3. 18 writes into a 16-deep TX FIFO
        fork
            begin
                logic [7:0] s;
                @(negedge clk); cs = 1'b1; we = 1'b1; addr = 2'd0;
                for (int i = 0; i < 18; i++) begin
                    data_in = 8'h80 + 8'(i);
                    @(negedge clk);
                end
                cs = 1'b0; we = 1'b0;
                peek(2'd1, s);
                check("status with TX full", s, 8'h12);
            end
            begin
                logic [7:0] b;
                logic       ok;
                for (int j = 0; j < 17; j++) begin
                    grab_tx(b, ok);
                    check($sformatf("tx frame %0d framing", j), ok, 1);
                    check($sformatf("tx frame %0d byte", j), b, 8'h80 + 8'(j));
                end
            end
        join
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
        end
        check("no 18th frame (low samples)", errs, 0);
        peek(2'd1, d);
        check("status after overflow drain", d, 8'h01);

        // 4. Receive, read, interrupt
        bus_write(2'd2, 8'h01);
        send_rx(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        peek(2'd1, d);
        check("status rx avail", d, 8'h05);
        peek(2'd3, d);
        check("rxcount one", d, 8'h01);
        check("rx irq", irq, 1);
        bus_read(2'd0, d);
        check("rx data", d, 8'hA5);
        peek(2'd3, d);
        check("rxcount after pop", d, 8'h00);
        check("irq still up after pop", irq, 1);
        @(negedge clk);
        check("irq fell", irq, 0);

        // 5. Glitch, framing error, W1C
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        peek(2'd1, d);
        check("status after glitch", d, 8'h01);
        peek(2'd3, d);
        check("rxcount after glitch", d, 8'h00);
        send_rx(8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        peek(2'd1, d);
        check("status framing error", d, 8'h41);
        peek(2'd3, d);
        check("rxcount after framing error", d, 8'h00);
        bus_write(2'd1, 8'h40);
        peek(2'd1, d);
        check("framing error cleared", d, 8'h01);

        // 6. RX overrun, read back, reset mid TX frame
        for (int k = 0; k < 17; k++) begin
            send_rx(8'h60 + 8'(k), 1'b1);
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        peek(2'd3, d);
        check("rxcount full", d, 8'h10);
        peek(2'd1, d);
        check("status overrun", d, 8'h2D);
        for (int k = 0; k < 16; k++) begin
            bus_read(2'd0, d);
            check($sformatf("rx readback %0d", k), d, 8'h60 + 8'(k));
        end
        peek(2'd3, d);
        check("rxcount drained", d, 8'h00);
        bus_write(2'd1, 8'h20);
        peek(2'd1, d);
        check("overrun cleared", d, 8'h01);

        send_rx(8'h77, 1'b1);
        bus_write(2'd0, 8'h00);
        repeat (30) @(negedge clk);
        check("tx low mid frame", tx, 0);
        peek(2'd3, d);
        check("rxcount before reset", d, 8'h01);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("tx after mid-frame reset", tx, 1);
        peek(2'd1, d);
        check("status after reset", d, 8'h01);
        peek(2'd3, d);
        check("rxcount after reset", d, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_fifo_periph.md
Name: uart_fifo_periph

Overview:
- Memory-mapped full-duplex UART peripheral for the 6502 system bus.
- Successor to the single-register transmit-only UART. Adds:
  - parametrised TX and RX FIFOs
  - receiver with mid-bit sampling, glitch rejection and error flags
  - status, control and count registers
  - level interrupt output
- Sits on the CPU bus at a 4-byte window, decoded externally into cs.

Parameters:
- CLK_FREQ, 25000000, system clock in Hz.
- BAUD_RATE, 9600, line rate. Bit period is DIV = CLK_FREQ/BAUD_RATE, truncated; DIV must be at least 4.
- FIFO_DEPTH, 16, entries per FIFO. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  2  register select.
- data_in  in  8  write data.
- data_out  out  8  read data, combinational from addr.
- cs  in  1  chip select.
- we  in  1  write strobe. Acts when cs&we are high for one cycle.
- re  in  1  read strobe. Acts when cs&re are high for one cycle; pops the RX FIFO on addr 0.
- tx  out  1  serial out; idle level is 1.
- rx  in  1  serial in, asynchronous.
- irq  out  1  active-high level interrupt.

Behaviour:
- Reset: tx=1, irq=0, both FIFOs empty, CTRL=0, error flags 0, TX and RX state machines IDLE. Status reads 0x01.
- Register map:
  - 0 DATA: write pushes TX FIFO. Read returns the RX FIFO head (0x00 if empty); a read strobe pops it. The value is presented in the same cycle, before the pop.
  - 1 STATUS:
    - b0 TX empty
    - b1 TX full
    - b2 RX available
    - b3 RX full
    - b4 TX busy (shifter active)
    - b5 overrun
    - b6 framing error
    - b7 = 0
    - Writing 1 to b5 or b6 clears that flag (W1C); other bits are read-only.
  - 2 CTRL: b0 RX irq enable, b1 TX-idle irq enable, others read 0.
  - 3 RXCOUNT: RX FIFO occupancy, zero-extended.
- irq = (CTRL.b0 & RX available) | (CTRL.b1 & TX empty & !busy). Registered: updates the cycle after its inputs change.
- FIFO rules:
  - Count width is clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Push when full: data dropped, no state change. TX overflow sets no flag.
  - Pop when empty: ignored.
  - Simultaneous push and pop: both take effect and the count is unchanged. This holds when full (for RX, when the pop and the completed frame coincide).
- TX state machine, IDLE -> START -> DATA -> STOP:
  - IDLE: if the FIFO is non-empty, pop into the shifter, set busy and go to START.
  - START: tx=0 for DIV cycles.
  - DATA: 8 bits LSB first, DIV cycles each.
  - STOP: tx=1 for DIV cycles. At the end of STOP, if the FIFO is non-empty, reload and re-enter START in the next cycle (back-to-back, no idle gap). Otherwise return to IDLE and clear busy.
  - Latency: a write in cycle N updates the FIFO count at N+1; tx falls at N+2 when the peripheral was idle.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - IDLE: a falling edge moves to START.
  - START: wait DIV/2 cycles. If the line is still 0, go to DATA; if it is 1, treat it as a glitch and return to IDLE.
  - DATA: sample every DIV cycles, 8 bits, LSB first.
  - STOP: sample once. If 1: push the byte, or if the FIFO is full (and no pop that cycle) drop it and set overrun. If 0: discard the byte, set framing error, and wait for the line to return to 1 before IDLE.
  - Flags are sticky until W1C.
- Simultaneous W1C and a new error event in the same cycle: the flag stays set.
- rst mid-frame: tx goes to 1 on the next edge; both shifters abort and the FIFOs clear.

Test Plan:
Bench parameters: CLK_FREQ=1000000, BAUD_RATE=100000 (DIV=10), FIFO_DEPTH=16.
1. Reset -> tx=1, STATUS=0x01, CTRL=0x00, RXCOUNT=0, irq=0.
2. Write 0x58 then 0x41 on consecutive cycles -> tx low at N+2. Line bits 0,0,0,0,1,1,0,1,0,1, each 10 cycles. Second frame starts the cycle after the first stop bit, with no gap. Busy clears after the second stop bit; with CTRL=0x02, irq rises one cycle later.
3. 18 writes on consecutive cycles from idle -> TX full seen; 17 frames transmitted in order; 18th byte absent.
4. Drive an rx frame of 0xA5 with CTRL=0x01 -> STATUS b2=1, RXCOUNT=1, irq=1. Read addr 0 with re -> returns 0xA5; next cycle RXCOUNT=0; irq falls the following cycle.
5. A 3-cycle low pulse on rx -> no byte and no flags. A 0x3C frame with stop bit 0 -> STATUS b6=1, RXCOUNT=0. Writing 0x40 to STATUS -> b6=0.
6. 17 frames with no reads -> RXCOUNT=16, overrun=1, first 16 bytes read back intact. Assert rst mid-TX-frame -> tx=1 next cycle and STATUS=0x01.
